// File: rtl/otter_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package otter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEF = 15;
  localparam int ARB_WDOG_W      = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first requester at or after ptr wins, wrapping
// modulo NUM_REQ; with fixed set the search always starts at index 0.
module rr_pick
  import otter_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic               fixed,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [SEL_W-1:0]   win_idx,
  output logic               win_vld
);

  always_comb begin
    int               base;
    logic [SEL_W-1:0] cand;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    base    = fixed ? 0 : int'(ptr);
    cand    = '0;
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = SEL_W'((base + i) % NUM_REQ);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    if (win_vld) begin
      win_oh[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between NUM_REQ requesters: round-robin or fixed
// priority, locked back-to-back transfers and a watchdog on MEM_ACK.
module mem_port_arbiter
  import otter_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ),
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] LOCK,
  input  logic               FIXED_PRIO,
  input  logic               MEM_ACK,
  output logic [NUM_REQ-1:0] GNT,
  output logic [SEL_W-1:0]   SEL,
  output logic               MEM_STB,
  output logic [NUM_REQ-1:0] DONE,
  output logic               ERR,
  output logic               BUSY
);

  localparam logic [ARB_WDOG_W-1:0] WDOG_LAST = ARB_WDOG_W'(TIMEOUT - 1);

  arb_state_t              state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    stb_q, stb_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    err_q, err_d;
  logic [SEL_W-1:0]        ptr_q, ptr_d;
  logic [ARB_WDOG_W-1:0]   wdog_q, wdog_d;
  logic                    rst_n_sync_q;

  logic [NUM_REQ-1:0]      pick_oh;
  logic [SEL_W-1:0]        pick_idx;
  logic                    pick_vld;

  function automatic logic [SEL_W-1:0] ptr_after(input logic [SEL_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // Assert asynchronously, release one clock after RST_N rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_n_sync_q <= 1'b0;
    end else begin
      rst_n_sync_q <= 1'b1;
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .fixed   (FIXED_PRIO),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    stb_d   = 1'b0;
    done_d  = '0;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_oh;
          sel_d   = pick_idx;
          stb_d   = 1'b1;
          state_d = ISSUE;
        end else begin
          gnt_d = '0;
          sel_d = '0;
        end
      end

      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // An ack landing on the last watchdog cycle still completes cleanly.
        if (MEM_ACK) begin
          done_d = gnt_q;
          if (LOCK[sel_q] && REQ[sel_q]) begin
            stb_d   = 1'b1;
            state_d = ISSUE;
          end else begin
            ptr_d   = ptr_after(sel_q);
            gnt_d   = '0;
            sel_d   = '0;
            state_d = IDLE;
          end
        end else if (wdog_q == WDOG_LAST) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          ptr_d   = ptr_after(sel_q);
          gnt_d   = '0;
          sel_d   = '0;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      default: begin
        gnt_d   = '0;
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n_sync_q) begin
    if (!rst_n_sync_q) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  assign GNT     = gnt_q;
  assign SEL     = sel_q;
  assign MEM_STB = stb_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign BUSY    = (state_q != IDLE);

  a_gnt_onehot : assert property (@(posedge CLK) disable iff (!rst_n_sync_q)
    $onehot0(gnt_q));
  a_sel_match : assert property (@(posedge CLK) disable iff (!rst_n_sync_q)
    (gnt_q != '0) |-> gnt_q[sel_q]);
  a_stb_issue : assert property (@(posedge CLK) disable iff (!rst_n_sync_q)
    stb_q |-> (state_q == ISSUE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 15;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic [NUM_REQ-1:0] REQ;
  logic [NUM_REQ-1:0] LOCK;
  logic               FIXED_PRIO;
  logic               MEM_ACK = 1'b0;
  logic [NUM_REQ-1:0] GNT;
  logic [SEL_W-1:0]   SEL;
  logic               MEM_STB;
  logic [NUM_REQ-1:0] DONE;
  logic               ERR;
  logic               BUSY;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 1;
  int ack_pct   = 0;
  int ack_cnt   = 0;

  mem_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ        (REQ),
    .LOCK       (LOCK),
    .FIXED_PRIO (FIXED_PRIO),
    .MEM_ACK    (MEM_ACK),
    .GNT        (GNT),
    .SEL        (SEL),
    .MEM_STB    (MEM_STB),
    .DONE       (DONE),
    .ERR        (ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Memory responder: either ack ack_delay cycles after each strobe
  // (0 = never), or random acks with probability ack_pct percent.
  always @(negedge CLK) begin
    if (ack_pct > 0) begin
      MEM_ACK = ($urandom_range(0, 99) < ack_pct);
    end else begin
      MEM_ACK = 1'b0;
      if (!RST_N) ack_cnt = 0;
      else if (MEM_STB) ack_cnt = ack_delay;
      else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) MEM_ACK = 1'b1;
      end
    end
  end

  // Reference model: owner of the port (-1 if none) and the age of the
  // current transfer counted in cycles since its strobe.
  typedef struct packed {
    int                 owner;
    int                 age;
    int                 ptr;
    logic               hold;
    logic               stb;
    logic [NUM_REQ-1:0] done;
    logic               err;
  } mstate_t;

  mstate_t m;

  function automatic int pick(logic [NUM_REQ-1:0] r, int start);
    int j;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (start + k) % NUM_REQ;
      if (r[j[SEL_W-1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(mstate_t c, logic [NUM_REQ-1:0] req,
                                         logic [NUM_REQ-1:0] lock, logic fixed, logic ack);
    mstate_t n;
    int w;
    n = c;
    n.stb  = 1'b0;
    n.done = '0;
    n.err  = 1'b0;
    if (c.hold) begin
      n.hold = 1'b0;
    end else if (c.owner < 0) begin
      w = pick(req, fixed ? 0 : c.ptr);
      if (w >= 0) begin
        n.owner = w;
        n.age   = 0;
        n.stb   = 1'b1;
      end
    end else if (c.age == 0) begin
      n.age = 1;
    end else if (ack || c.age == TIMEOUT) begin
      n.done = NUM_REQ'(1 << c.owner);
      n.err  = !ack;
      if (ack && lock[c.owner[SEL_W-1:0]] && req[c.owner[SEL_W-1:0]]) begin
        n.age = 0;
        n.stb = 1'b1;
      end else begin
        n.ptr   = (c.owner + 1) % NUM_REQ;
        n.owner = -1;
      end
    end else begin
      n.age = c.age + 1;
    end
    return n;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m <= '{owner: -1, age: 0, ptr: 0, hold: 1'b1, stb: 1'b0, done: '0, err: 1'b0};
    else        m <= model_next(m, REQ, LOCK, FIXED_PRIO, MEM_ACK);
  end

  logic [NUM_REQ-1:0] exp_gnt;
  logic [SEL_W-1:0]   exp_sel;
  logic               exp_busy;
  always_comb begin
    exp_gnt  = '0;
    exp_sel  = '0;
    exp_busy = 1'b0;
    if (m.owner >= 0) begin
      exp_gnt  = NUM_REQ'(1 << m.owner);
      exp_sel  = SEL_W'(m.owner);
      exp_busy = 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    REQ   = '0;
    LOCK  = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    ack_pct = 0; ack_delay = 1;
    @(negedge CLK);
    RST_N = 1'b0; REQ = 4'b1111; LOCK = '0; FIXED_PRIO = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_checks++;
      if ({GNT, SEL, MEM_STB, DONE, ERR, BUSY} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_hold got=%h want=000", {GNT, SEL, MEM_STB, DONE, ERR, BUSY});
      end
    end
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({GNT, BUSY} !== 5'b0) begin
      n_fail++;
      $display("FAIL release_edge1 got=%b want=00000", {GNT, BUSY});
    end
    @(negedge CLK);
    n_checks++;
    if ({GNT, SEL, MEM_STB, BUSY} !== {4'b0001, 2'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL first_grant got=%b want=00010011", {GNT, SEL, MEM_STB, BUSY});
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5];
    int nstb = 0;
    int ndone = 0;
    int last = 0;
    exp_seq = '{0, 1, 2, 3, 0};
    do_reset();
    FIXED_PRIO = 1'b0; REQ = 4'b1111; ack_delay = 1;
    for (int cyc = 0; cyc < 60 && nstb < 5; cyc++) begin
      @(negedge CLK);
      if (DONE !== '0) begin
        ndone++;
        n_checks++;
        if (DONE !== NUM_REQ'(1 << last)) begin
          n_fail++;
          $display("FAIL rr_done got=%b want=%b", DONE, NUM_REQ'(1 << last));
        end
      end
      if (MEM_STB) begin
        n_checks++;
        if (int'(SEL) != exp_seq[nstb]) begin
          n_fail++;
          $display("FAIL rr_sel got=%0d want=%0d", SEL, exp_seq[nstb]);
        end
        last = int'(SEL);
        nstb++;
      end
    end
    n_checks++;
    if (nstb != 5 || ndone != 4) begin
      n_fail++;
      $display("FAIL rr_counts got=%0d/%0d want=5/4", nstb, ndone);
    end
  endtask

  task automatic test_fixed_prio();
    int nstb = 0;
    logic saw3 = 1'b0;
    do_reset();
    FIXED_PRIO = 1'b1; REQ = 4'b1010; ack_delay = $urandom_range(1, 4);
    for (int cyc = 0; cyc < 80 && nstb < 5; cyc++) begin
      @(negedge CLK);
      saw3 |= GNT[3];
      if (MEM_STB) begin
        nstb++;
        n_checks++;
        if (SEL !== 2'd1) begin
          n_fail++;
          $display("FAIL fixed_sel got=%0d want=1", SEL);
        end
      end
    end
    n_checks++;
    if (nstb != 5 || saw3 !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_starve got=%0d/%b want=5/0", nstb, saw3);
    end
    FIXED_PRIO = 1'b0;
  endtask

  task automatic test_lock_burst();
    int stb_cyc[4];
    int stb_sel[4];
    int nstb = 0;
    int idle_gap = 0;
    do_reset();
    FIXED_PRIO = 1'b0; REQ = 4'b0100; LOCK = 4'b0100; ack_delay = 1;
    for (int cyc = 0; cyc < 40 && nstb < 4; cyc++) begin
      @(negedge CLK);
      if (nstb >= 1 && !BUSY) idle_gap++;
      if (MEM_STB) begin
        stb_cyc[nstb] = cyc;
        stb_sel[nstb] = int'(SEL);
        nstb++;
        if (nstb == 1) REQ = 4'b0101;
        if (nstb == 3) LOCK = 4'b0000;
      end
    end
    n_checks++;
    if (nstb != 4) begin
      n_fail++;
      $display("FAIL lock_count got=%0d want=4", nstb);
    end else begin
      n_checks++;
      if ({stb_sel[0], stb_sel[1], stb_sel[2], stb_sel[3]} != {32'd2, 32'd2, 32'd2, 32'd0}) begin
        n_fail++;
        $display("FAIL lock_sel got=%0d,%0d,%0d,%0d want=2,2,2,0",
                 stb_sel[0], stb_sel[1], stb_sel[2], stb_sel[3]);
      end
      n_checks++;
      if (stb_cyc[1] - stb_cyc[0] != 2 || stb_cyc[2] - stb_cyc[1] != 2 ||
          stb_cyc[3] - stb_cyc[2] != 3 || idle_gap != 1) begin
        n_fail++;
        $display("FAIL lock_spacing got=%0d,%0d,%0d idle=%0d want=2,2,3 idle=1",
                 stb_cyc[1] - stb_cyc[0], stb_cyc[2] - stb_cyc[1], stb_cyc[3] - stb_cyc[2], idle_gap);
      end
    end
    LOCK = '0;
  endtask

  task automatic test_timeout();
    int s = -1;
    do_reset();
    FIXED_PRIO = 1'b0; REQ = 4'b0010; ack_delay = 0;
    for (int c = 0; c < 10 && s < 0; c++) begin
      @(negedge CLK);
      if (MEM_STB) s = c;
    end
    n_checks++;
    if (s < 0) begin
      n_fail++;
      $display("FAIL to_strobe got=none want=strobe");
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      n_checks++;
      if (k < 16 && {BUSY, ERR, DONE} !== 6'b100000) begin
        n_fail++;
        $display("FAIL to_wait k=%0d got=%b want=100000", k, {BUSY, ERR, DONE});
      end else if (k == 16 && {BUSY, ERR, DONE} !== 6'b010010) begin
        n_fail++;
        $display("FAIL to_err got=%b want=010010", {BUSY, ERR, DONE});
      end
    end
    REQ = 4'b0111;
    @(negedge CLK);
    n_checks++;
    if ({MEM_STB, SEL} !== 3'b110) begin
      n_fail++;
      $display("FAIL to_next_ptr got=%b want=110", {MEM_STB, SEL});
    end
  endtask

  task automatic test_collision();
    int s = -1;
    do_reset();
    FIXED_PRIO = 1'b0; REQ = 4'b0010; ack_delay = TIMEOUT;
    for (int c = 0; c < 10 && s < 0; c++) begin
      @(negedge CLK);
      if (MEM_STB) s = c;
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k == 16) begin
        n_checks++;
        if ({BUSY, ERR, DONE} !== 6'b000010) begin
          n_fail++;
          $display("FAIL collide got=%b want=000010", {BUSY, ERR, DONE});
        end
      end else if (ERR !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL collide_early k=%0d got=%b want=0", k, ERR);
      end
    end
  endtask

  task automatic test_withdraw();
    int s = -1;
    do_reset();
    FIXED_PRIO = 1'b0; REQ = 4'b1000; ack_delay = 3;
    for (int c = 0; c < 10 && s < 0; c++) begin
      @(negedge CLK);
      if (MEM_STB) s = c;
    end
    REQ = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      n_checks++;
      if (k <= 3 && {GNT, DONE} !== 8'b1000_0000) begin
        n_fail++;
        $display("FAIL wd_hold k=%0d got=%b want=10000000", k, {GNT, DONE});
      end else if (k == 4 && {ERR, DONE} !== 5'b01000) begin
        n_fail++;
        $display("FAIL wd_done got=%b want=01000", {ERR, DONE});
      end else if (k == 5 && {MEM_STB, SEL} !== 3'b100) begin
        n_fail++;
        $display("FAIL wd_next got=%b want=100", {MEM_STB, SEL});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    ack_pct = 30;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge CLK);
      n_checks++;
      if ({GNT, SEL, MEM_STB, DONE, ERR, BUSY} !== {exp_gnt, exp_sel, m.stb, m.done, m.err, exp_busy}) begin
        n_fail++;
        $display("FAIL rand_vec cyc=%0d got=%b want=%b", cyc, {GNT, SEL, MEM_STB, DONE, ERR, BUSY},
                 {exp_gnt, exp_sel, m.stb, m.done, m.err, exp_busy});
      end
      n_checks++;
      if (!$onehot0(GNT) || (GNT !== '0 && GNT[SEL] !== 1'b1)) begin
        n_fail++;
        $display("FAIL rand_invariant cyc=%0d got=%b/%0d want=onehot0-matching", cyc, GNT, SEL);
      end
      if (cyc == 150) ack_pct = 5;
      if (cyc == 300) ack_pct = 30;
      if ($urandom_range(0, 3) == 0) REQ = NUM_REQ'($urandom);
      LOCK = NUM_REQ'($urandom);
      if ($urandom_range(0, 15) == 0) FIXED_PRIO = ~FIXED_PRIO;
      RST_N = !(cyc >= 250 && cyc < 252);
    end
    ack_pct = 0;
  endtask

  initial begin
    RST_N = 1'b0; REQ = '0; LOCK = '0; FIXED_PRIO = 1'b0;
    test_reset();
    test_round_robin();
    test_fixed_prio();
    test_lock_burst();
    test_timeout();
    test_collision();
    test_withdraw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
